// File: rtl/serial_ripple_subtractor_if.sv
// rtl/serial_ripple_subtractor_if.sv - operand/result handshake bundle for the serial subtractor
interface serial_ripple_subtractor_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             fault;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, fault
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, fault
    );
endinterface

// File: rtl/serial_ripple_subtractor.sv
// rtl/serial_ripple_subtractor.sv - nibble-serial a-b-bin subtractor; SERIAL_SUB_DMR_EN adds a duplicate checking slice
module serial_ripple_subtractor #(
    parameter int WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    serial_ripple_subtractor_if.slave bus
);
    localparam int N  = WIDTH / 4;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_bout;
    logic [KW-1:0]    r_k;
    logic             r_fault;

    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic [4:0]       w_pri_res;
    logic             w_mismatch;

    // Bit-level ripple-borrow slice; returns {borrow_out, diff[3:0]}
    function automatic logic [4:0] f_slice(input logic [3:0] fa, input logic [3:0] fb, input logic fbr);
        logic       br;
        logic [3:0] d;
        br = fbr;
        d  = '0;
        for (int i = 0; i < 4; i++) begin
            d[i] = fa[i] ^ fb[i] ^ br;
            br   = (~fa[i] & fb[i]) | (~(fa[i] ^ fb[i]) & br);
        end
        return {br, d};
    endfunction

    assign w_a_nib   = r_a[4*r_k +: 4];
    assign w_b_nib   = r_b[4*r_k +: 4];
    assign w_pri_res = f_slice(w_a_nib, w_b_nib, r_borrow);

`ifdef SERIAL_SUB_DMR_EN
    logic [4:0] w_dup_res;
    // Checker uses a differently-structured arithmetic form so a shared fault is unlikely
    assign w_dup_res  = {1'b0, w_a_nib} - {1'b0, w_b_nib} - {4'b0000, r_borrow};
    assign w_mismatch = (w_dup_res != w_pri_res);
`else
    assign w_mismatch = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_k      <= '0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a      <= bus.a;
                        r_b      <= bus.b;
                        r_borrow <= bus.bin;
                        r_diff   <= '0;
                        r_k      <= '0;
                        r_fault  <= 1'b0;
                        r_state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_diff[4*r_k +: 4] <= w_pri_res[3:0];
                    r_borrow           <= w_pri_res[4];
                    r_fault            <= r_fault | w_mismatch;
                    if (r_k == KW'(N - 1)) begin
                        r_bout  <= w_pri_res[4];
                        r_state <= S_DONE;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.diff      = r_diff;
    assign bus.bout      = r_bout;
`ifdef SERIAL_SUB_DMR_EN
    assign bus.fault     = r_fault;
`else
    assign bus.fault     = 1'b0;
`endif
endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// tb/tb_serial_ripple_subtractor.sv - randomized self-checking bench for serial_ripple_subtractor
module tb_serial_ripple_subtractor;
    localparam int W = 16;
    localparam int N = W / 4;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    serial_ripple_subtractor_if #(.WIDTH(W)) bus ();

    serial_ripple_subtractor #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain wide arithmetic, borrow is the sign bit of the widened difference
    function automatic logic [W:0] ref_sub(input logic [W-1:0] ra, input logic [W-1:0] rb, input logic rbin);
        logic [W:0] full;
        full = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
        return full;
    endfunction

    // Issues one operation, waits for the result, captures it, then consumes it
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbin,
                          output logic [W-1:0] d, output logic bo, output logic f,
                          output int lat, output logic rdy_seen);
        bus.a = ta; bus.b = tb; bus.bin = tbin;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
        lat = 0; rdy_seen = 1'b0;
        while (!bus.out_valid && lat < 50) begin
            if (bus.in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        if (bus.in_ready) rdy_seen = 1'b1;
        d = bus.diff; bo = bus.bout; f = bus.fault;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        n_cmp++; if (bus.diff !== '0 || bus.bout !== 1'b0 || bus.fault !== 1'b0)
            begin n_err++; $display("FAIL reset_outputs got diff=%h bout=%b fault=%b exp 0/0/0", bus.diff, bus.bout, bus.fault); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        logic         vbin [4];
        logic [W-1:0] d;
        logic         bo, f, rs;
        logic [W:0]   e;
        int           lat;
        va[0] = 16'h1234; vb[0] = 16'h0234; vbin[0] = 1'b0;
        va[1] = 16'h0000; vb[1] = 16'h0001; vbin[1] = 1'b0;
        va[2] = 16'h8000; vb[2] = 16'h7FFF; vbin[2] = 1'b1;
        va[3] = 16'hFFFF; vb[3] = 16'hFFFF; vbin[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            e = ref_sub(va[i], vb[i], vbin[i]);
            run_op(va[i], vb[i], vbin[i], d, bo, f, lat, rs);
            n_cmp++; if (lat !== N) begin n_err++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, N); end
            n_cmp++; if (d !== e[W-1:0]) begin n_err++; $display("FAIL dir%0d_diff got=%h exp=%h", i, d, e[W-1:0]); end
            n_cmp++; if (bo !== e[W]) begin n_err++; $display("FAIL dir%0d_bout got=%b exp=%b", i, bo, e[W]); end
            n_cmp++; if (rs !== 1'b0) begin n_err++; $display("FAIL dir%0d_in_ready_busy got=%b exp=0", i, rs); end
            n_cmp++; if (f !== 1'b0) begin n_err++; $display("FAIL dir%0d_fault got=%b exp=0", i, f); end
        end
    endtask

    task automatic test_random_back_to_back();
        logic [W-1:0] ra, rb, d;
        logic         rbin, bo, f, rs;
        logic [W:0]   e;
        int           lat;
        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
            if (i % 5 == 0) ra = rb;
            e = ref_sub(ra, rb, rbin);
            run_op(ra, rb, rbin, d, bo, f, lat, rs);
            n_cmp++; if (d !== e[W-1:0] || bo !== e[W] || lat !== N)
                begin n_err++; $display("FAIL rnd%0d got diff=%h bout=%b lat=%0d exp diff=%h bout=%b lat=%0d", i, d, bo, lat, e[W-1:0], e[W], N); end
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rnd%0d_ready_after got=%b exp=1", i, bus.in_ready); end
        end
    endtask

    task automatic test_backpressure();
        logic [W:0] e;
        int         lat;
        e = ref_sub(16'h4321, 16'h5678, 1'b1);
        bus.a = 16'h4321; bus.b = 16'h5678; bus.bin = 1'b1;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (lat !== N) begin n_err++; $display("FAIL bp_latency got=%0d exp=%0d", lat, N); end
        for (int c = 0; c < 6; c++) begin
            bus.in_valid = 1'($urandom); bus.a = W'($urandom); bus.b = W'($urandom); bus.bin = 1'($urandom);
            @(posedge clk); #1;
            n_cmp++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.diff !== e[W-1:0] || bus.bout !== e[W])
                begin n_err++; $display("FAIL bp_hold%0d got v=%b r=%b diff=%h bout=%b exp v=1 r=0 diff=%h bout=%b",
                                        c, bus.out_valid, bus.in_ready, bus.diff, bus.bout, e[W-1:0], e[W]); end
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
            begin n_err++; $display("FAIL bp_release got r=%b v=%b exp r=1 v=0", bus.in_ready, bus.out_valid); end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] d;
        logic         bo, f, rs;
        int           lat;
        bus.a = 16'hABCD; bus.b = 16'h1111; bus.bin = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.diff !== '0 || bus.bout !== 1'b0 || bus.fault !== 1'b0)
            begin n_err++; $display("FAIL midreset_outputs got r=%b v=%b diff=%h bout=%b fault=%b exp 1/0/0/0/0",
                                    bus.in_ready, bus.out_valid, bus.diff, bus.bout, bus.fault); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(16'h0005, 16'h0003, 1'b0, d, bo, f, lat, rs);
        n_cmp++; if (d !== 16'h0002 || bo !== 1'b0 || lat !== N)
            begin n_err++; $display("FAIL midreset_next got diff=%h bout=%b lat=%0d exp diff=0002 bout=0 lat=%0d", d, bo, lat, N); end
    endtask

`ifdef SERIAL_SUB_DMR_EN
    task automatic test_fault();
        logic [W-1:0] d;
        logic         bo, f, rs;
        logic [W:0]   e;
        int           lat;
        e = ref_sub(16'h9A3C, 16'h12F7, 1'b0);
        bus.a = 16'h9A3C; bus.b = 16'h12F7; bus.bin = 1'b0;
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        force dut.w_dup_res = dut.w_pri_res ^ 5'b00001;
        @(posedge clk); #1;
        release dut.w_dup_res;
        lat = 0;
        while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        n_cmp++; if (bus.fault !== 1'b1) begin n_err++; $display("FAIL dmr_fault_set got=%b exp=1", bus.fault); end
        n_cmp++; if (bus.diff !== e[W-1:0] || bus.bout !== e[W])
            begin n_err++; $display("FAIL dmr_diff got diff=%h bout=%b exp diff=%h bout=%b", bus.diff, bus.bout, e[W-1:0], e[W]); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        run_op(16'h0F0F, 16'h00FF, 1'b1, d, bo, f, lat, rs);
        n_cmp++; if (f !== 1'b0) begin n_err++; $display("FAIL dmr_fault_clear got=%b exp=0", f); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.bin = 1'b0;
        rst_n = 1'b1;
        test_reset();
        test_directed();
        test_random_back_to_back();
        test_backpressure();
        test_reset_mid_run();
`ifdef SERIAL_SUB_DMR_EN
        test_fault();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
